writeback_ctrl: RTL and testbench
=================================

Name: writeback_ctrl

Overview:
- Write-port initiator for the 32x32 register file.
- Accepts results from two producers, the ALU and the load/store unit, over valid/ready handshakes.
- Arbitrates them onto the single register-file write port (`write_enable`/`write`/`data`), registered with one-cycle latency.
- Keeps a per-register busy scoreboard that decode uses to stall on pending writes (RAW hazard detection).

Parameters:
- XLEN, 32, data width of results and write port.
- STARVE_LIMIT, 4, consecutive cycles ALU may be blocked by MEM before ALU is forced to win.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alu_valid  input  1  ALU result available.
- alu_ready  output  1  ALU result accepted this cycle (combinational).
- alu_rd  input  5  ALU destination register.
- alu_data  input  XLEN  ALU result.
- mem_valid  input  1  load result available.
- mem_ready  output  1  load result accepted this cycle (combinational).
- mem_rd  input  5  load destination register.
- mem_data  input  XLEN  load result.
- issue_valid  input  1  instruction with a destination is issued this cycle.
- issue_rd  input  5  destination of issued instruction; marks it busy.
- regaddr1  input  5  source register 1 queried by decode.
- regaddr2  input  5  source register 2 queried by decode.
- busy1  output  1  regaddr1 has a pending write (combinational).
- busy2  output  1  regaddr2 has a pending write (combinational).
- write_enable  output  1  register-file write strobe (registered).
- write  output  5  register-file write address (registered).
- data  output  XLEN  register-file write data (registered).

Behaviour:
- Reset: asserting `rst_n` low immediately clears the following, regardless of `clk`:
  - `write_enable` = 0, `write` = 0, `data` = 0.
  - Busy vector = all 0.
  - Starvation counter = 0.
- Reset mid-operation: in-flight handshakes are discarded, and all registers read not-busy after reset.
- Arbitration (combinational), one grant per cycle:
  - Normal: MEM has priority. `mem_ready` = `mem_valid` & !force_alu. `alu_ready` = `alu_valid` & (!`mem_valid` | force_alu).
  - force_alu = (starve_cnt == STARVE_LIMIT).
  - Exactly one producer is accepted per cycle at most. Neither ready is asserted without its own valid.
- Starvation counter, updated at the clock edge:
  - Increments when `alu_valid` & `mem_valid` & MEM granted.
  - Clears to 0 when ALU is granted or `alu_valid` = 0.
  - Saturates at STARVE_LIMIT.
- Handshake rules:
  - A transfer occurs when valid & ready are both high at a rising edge.
  - Producers hold rd/data stable while valid & !ready.
  - Both ready outputs are independent of the write output registers; the port never back-pressures except by arbitration.
- Output register, updated at the edge of an accepted transfer:
  - `write_enable` <= (granted rd != 0).
  - `write` <= granted rd.
  - `data` <= granted data.
  - With no transfer, `write_enable` <= 0 and `write`/`data` hold their previous values.
  - Latency: accept at edge N, register file writes at edge N+1.
- Writes to x0: accepted (ready asserted), dropped (`write_enable` stays 0), busy unaffected.
- Scoreboard, a 32-bit busy vector; bit 0 is always 0:
  - Set: at the edge, if `issue_valid` & `issue_rd` != 0 → busy[`issue_rd`] <= 1.
  - Clear: at the edge, if `write_enable` → busy[`write`] <= 0.
  - The clear happens on the same edge the register file commits the write.
  - Simultaneous set and clear of the same register: set wins (new producer outstanding).
- Query outputs (combinational): `busy1` = busy[`regaddr1`], `busy2` = busy[`regaddr2`]; reading 0 always returns 0.
  - In the cycle `write_enable` = 1 for register r, busy[r] still reads 1, because the register file's asynchronous read returns the old value until the edge.
- Out-of-order completion to the same rd is outside this block's responsibility; the latest write clears busy.

Test Plan:
- Reset/idle: hold `rst_n` = 0 mid-cycle with busy[5] = 1 → `write_enable` = 0, `write` = 0, `data` = 0, `busy1` (regaddr1 = 5) = 0 immediately, without a clock edge.
- Single ALU write:
  - issue rd = 7, then `alu_valid` with rd = 7, data = 0xDEADBEEF.
  - Expect `alu_ready` = 1 and, on the next cycle, `write_enable` = 1, `write` = 7, `data` = 0xDEADBEEF.
  - `busy1` (regaddr1 = 7) reads 1 through that cycle and 0 after the edge.
- Contention: `alu_valid` and `mem_valid` held continuously, with distinct rd values.
  - Expect 4 consecutive MEM grants, then 1 ALU grant with `mem_ready` = 0, then the pattern repeats.
  - Verify no cycle has both ready outputs high.
- x0 drop: `mem_valid` with rd = 0, data = 0x12345678 → `mem_ready` = 1, next-cycle `write_enable` = 0; `busy1` (regaddr1 = 0) = 0 throughout.
- Set/clear collision:
  - `write_enable` for rd = 3 on the same edge as `issue_valid` with `issue_rd` = 3 → busy[3] remains 1 afterward.
  - A second write to 3 then clears it.
- Back-to-back throughput: 8 consecutive ALU transfers with rd = 1..8 → 8 consecutive `write_enable` pulses, in order, with 1-cycle latency and no bubbles.

Source files
------------

// File: rtl/writeback_ctrl_if.sv
// rtl/writeback_ctrl_if.sv - producer, issue, query and register-file write-port signals of writeback_ctrl
interface writeback_ctrl_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            mem_valid;
    logic            mem_ready;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [4:0]      regaddr1;
    logic [4:0]      regaddr2;
    logic            busy1;
    logic            busy2;
    logic            write_enable;
    logic [4:0]      write;
    logic [XLEN-1:0] data;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  issue_valid, issue_rd, regaddr1, regaddr2,
        output alu_ready, mem_ready, busy1, busy2,
        output write_enable, write, data
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output issue_valid, issue_rd, regaddr1, regaddr2,
        input  alu_ready, mem_ready, busy1, busy2,
        input  write_enable, write, data
    );
endinterface

// File: rtl/writeback_ctrl.sv
// rtl/writeback_ctrl.sv - ALU/MEM writeback arbiter with registered write port and busy scoreboard
module writeback_ctrl #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    writeback_ctrl_if.slave  bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0]   starve_cnt;
    logic [CW-1:0]   starve_nxt;
    logic            force_alu;
    logic            grant_valid;
    logic [4:0]      grant_rd;
    logic [XLEN-1:0] grant_data;
    logic [31:0]     busy;
    logic [31:0]     busy_nxt;

    // MEM wins by default; a long-blocked ALU result is let through once.
    assign force_alu     = (starve_cnt == CW'(STARVE_LIMIT));
    assign bus.mem_ready = bus.mem_valid & ~force_alu;
    assign bus.alu_ready = bus.alu_valid & (~bus.mem_valid | force_alu);

    assign bus.busy1 = busy[bus.regaddr1];
    assign bus.busy2 = busy[bus.regaddr2];

    always_comb begin
        grant_valid = bus.alu_ready | bus.mem_ready;
        grant_rd    = bus.mem_rd;
        grant_data  = bus.mem_data;
        if (bus.alu_ready) begin
            grant_rd   = bus.alu_rd;
            grant_data = bus.alu_data;
        end
    end

    always_comb begin
        starve_nxt = '0;
        if (bus.alu_valid & bus.mem_valid & bus.mem_ready)
            starve_nxt = starve_cnt + CW'(1);
    end

    // Clear on commit, then set on issue so a new producer overrides the retiring one.
    always_comb begin
        busy_nxt = busy;
        if (bus.write_enable)
            busy_nxt[bus.write] = 1'b0;
        if (bus.issue_valid && bus.issue_rd != 5'd0)
            busy_nxt[bus.issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt       <= '0;
            busy             <= '0;
            bus.write_enable <= 1'b0;
            bus.write        <= 5'd0;
            bus.data         <= '0;
        end else begin
            starve_cnt       <= starve_nxt;
            busy             <= busy_nxt;
            bus.write_enable <= grant_valid & (grant_rd != 5'd0);
            if (grant_valid) begin
                bus.write <= grant_rd;
                bus.data  <= grant_data;
            end
        end
    end
endmodule

// File: tb/tb_writeback_ctrl.sv
// tb/tb_writeback_ctrl.sv - directed and randomized checks of writeback_ctrl against a reference model
module tb_writeback_ctrl;
    localparam int XLEN = 32;
    localparam int LIM  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    writeback_ctrl_if #(.XLEN(XLEN)) bus ();
    writeback_ctrl #(.XLEN(XLEN), .STARVE_LIMIT(LIM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_busy;
    logic        m_we;
    logic [4:0]  m_wr;
    logic [31:0] m_data;
    int          m_wait;
    logic        g_alu, g_mem, d_alu, d_mem;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = '0; m_we = 1'b0; m_wr = '0; m_data = '0; m_wait = 0;
        g_alu = 1'b0; g_mem = 1'b0;
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic iv, input logic [4:0] ird,
                         input logic [4:0] r1, input logic [4:0] r2);
        bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
        bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_data = md;
        bus.issue_valid = iv; bus.issue_rd = ird;
        bus.regaddr1 = r1; bus.regaddr2 = r2;
    endtask

    // One clock of the reference: predict grants and queries, then the registered result.
    task automatic cycle();
        logic ea, em, nwe;
        logic [4:0] nwr;
        logic [31:0] nd, nb;
        int nwait;
        #1;
        em = bus.mem_valid && (m_wait < LIM);
        ea = bus.alu_valid && (!bus.mem_valid || m_wait >= LIM);
        d_alu = bus.alu_ready;
        d_mem = bus.mem_ready;
        chk("alu_ready", bus.alu_ready, ea);
        chk("mem_ready", bus.mem_ready, em);
        chk("one_grant", bus.alu_ready & bus.mem_ready, 0);
        chk("busy1", bus.busy1, (bus.regaddr1 == 0) ? 1'b0 : m_busy[bus.regaddr1]);
        chk("busy2", bus.busy2, (bus.regaddr2 == 0) ? 1'b0 : m_busy[bus.regaddr2]);
        nwe = 1'b0; nwr = m_wr; nd = m_data;
        if (ea) begin
            nwe = (bus.alu_rd != 0); nwr = bus.alu_rd; nd = bus.alu_data;
        end else if (em) begin
            nwe = (bus.mem_rd != 0); nwr = bus.mem_rd; nd = bus.mem_data;
        end
        nb = m_busy;
        if (m_we) nb[m_wr] = 1'b0;
        if (bus.issue_valid && bus.issue_rd != 0) nb[bus.issue_rd] = 1'b1;
        if (bus.alu_valid && bus.mem_valid && em) nwait = (m_wait + 1 > LIM) ? LIM : m_wait + 1;
        else nwait = 0;
        g_alu = ea; g_mem = em;
        @(posedge clk);
        #1;
        m_we = nwe; m_wr = nwr; m_data = nd; m_busy = nb; m_wait = nwait;
        chk("write_enable", bus.write_enable, m_we);
        chk("write", bus.write, m_wr);
        chk("data", bus.data, m_data);
    endtask

    initial begin
        logic [31:0] a_data, m_dat;
        logic [4:0]  a_rd, m_rd;
        logic        a_v, m_v;

        rst_n = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_we", bus.write_enable, 0);
        chk("rst_write", bus.write, 0);
        chk("rst_data", bus.data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single ALU write with RAW scoreboard tracking
        drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0); cycle();
        drive(1, 7, 32'hDEADBEEF, 0, 0, 0, 0, 0, 7, 0); #1;
        chk("alu1_ready", bus.alu_ready, 1);
        chk("alu1_busy_pre", bus.busy1, 1);
        cycle();
        chk("alu1_we", bus.write_enable, 1);
        chk("alu1_write", bus.write, 7);
        chk("alu1_data", bus.data, 32'hDEADBEEF);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 0); #1;
        chk("alu1_busy_commit", bus.busy1, 1);
        cycle();
        chk("alu1_busy_after", bus.busy1, 0);

        // Contention: 4 MEM grants then one forced ALU grant, repeating
        drive(1, 10, 32'h0A0A0A0A, 1, 11, 32'h0B0B0B0B, 0, 0, 10, 11);
        for (int i = 0; i < 15; i++) begin
            cycle();
            chk("cont_mem", d_mem, (i % 5) != 4);
            chk("cont_alu", d_alu, (i % 5) == 4);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();

        // Write to x0 is accepted and dropped
        drive(0, 0, 0, 1, 0, 32'h12345678, 0, 0, 0, 0); #1;
        chk("x0_ready", bus.mem_ready, 1);
        chk("x0_busy_pre", bus.busy1, 0);
        cycle();
        chk("x0_we", bus.write_enable, 0);
        chk("x0_busy_post", bus.busy1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();

        // Set/clear collision on x3: set wins, second write clears
        drive(0, 0, 0, 0, 0, 0, 1, 3, 3, 0); cycle();
        drive(1, 3, 32'h33, 0, 0, 0, 0, 0, 3, 0); cycle();
        drive(0, 0, 0, 0, 0, 0, 1, 3, 3, 0); #1;
        chk("coll_we", bus.write_enable, 1);
        cycle();
        chk("coll_busy_kept", bus.busy1, 1);
        drive(1, 3, 32'h34, 0, 0, 0, 0, 0, 3, 0); cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 0); cycle();
        chk("coll_busy_cleared", bus.busy1, 0);

        // Back-to-back ALU throughput
        for (int i = 1; i <= 8; i++) begin
            drive(1, 5'(i), $urandom, 0, 0, 0, 0, 0, 5'(i), 0);
            cycle();
            chk("b2b_we", bus.write_enable, 1);
            chk("b2b_write", bus.write, i);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();

        // Randomized traffic; producers hold their offer until accepted
        a_v = 0; m_v = 0; a_rd = 0; m_rd = 0; a_data = 0; m_dat = 0;
        for (int i = 0; i < 400; i++) begin
            if (!a_v || g_alu) begin
                a_v = ($urandom_range(0, 3) != 0); a_rd = 5'($urandom); a_data = $urandom;
            end
            if (!m_v || g_mem) begin
                m_v = ($urandom_range(0, 4) != 0); m_rd = 5'($urandom); m_dat = $urandom;
            end
            drive(a_v, a_rd, a_data, m_v, m_rd, m_dat, ($urandom_range(0, 1) == 1),
                  5'($urandom), 5'($urandom), 5'($urandom));
            cycle();
        end

        // Asynchronous reset in mid-cycle with x5 busy and a live write port
        drive(0, 0, 0, 0, 0, 0, 1, 5, 5, 0); cycle();
        drive(1, 9, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 5, 0); cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 0); #2;
        chk("mid_busy_pre", bus.busy1, 1);
        chk("mid_we_pre", bus.write_enable, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_we", bus.write_enable, 0);
        chk("mid_write", bus.write, 0);
        chk("mid_data", bus.data, 0);
        chk("mid_busy1", bus.busy1, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int r = 0; r < 32; r++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 5'(r), 5'(31 - r)); #1;
            chk("post_rst_busy1", bus.busy1, 0);
            chk("post_rst_busy2", bus.busy2, 0);
        end
        drive(1, 12, 32'hCAFEF00D, 1, 13, 32'h0D0D0D0D, 0, 0, 12, 13); cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
